imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart to the instruction ROM: fills the instruction RAM at run time
//  instead of at elaboration. Accepts a byte stream (valid/ready, last), packs bytes
//  big-endian into 32-bit Instructions and writes them to consecutive addresses from 0.
//  Holds the CPU (hold_cpu) while loading; sits between the host/debug link and the
//  instruction-memory write port.
// PARAMETERS
//  IW   4   log2 of instruction-memory depth; 2**IW words writable (matches memory IW)
// PORTS
//  CLK          in   1          system clock, all state on rising edge
//  reset_n      in   1          asynchronous, active-low reset
//  start        in   1          1-cycle pulse: begin a load (honoured only in IDLE)
//  s_data       in   8          stream byte
//  s_valid      in   1          s_data valid
//  s_last       in   1          qualifies final byte of the program (with s_valid)
//  s_ready      out  1          loader accepts byte this cycle
//  wr_en        out  1          instruction-memory write strobe (1 cycle per word)
//  wr_addr      out  ProgramCounter  word address; upper bits above IW always 0
//  wr_data      out  Instruction (32) packed word
//  busy         out  1          load in progress (any state but IDLE)
//  hold_cpu     out  1          = busy; CPU must not fetch while high
//  done         out  1          1-cycle pulse at end of load
//  err          out  1          sticky overflow flag; cleared by next accepted start
//  words_loaded out  IW+1       words written in current/last load
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; s_ready, wr_en, busy, hold_cpu, done, err=0;
//    wr_addr, wr_data, words_loaded, byte index, pack register=0. Memory untouched.
//  - Handshake: byte transfers iff s_valid && s_ready in same cycle; s_ready never
//    depends combinationally on s_valid. s_data/s_last sampled only on transfer.
//  - IDLE: s_ready=0. start -> RECV; clear words_loaded, err, byte index, pack reg.
//    start in any other state ignored.
//  - RECV: s_ready=1. Byte k (0..3) of word goes to bits [31-8k -: 8] (first byte = MSB).
//    After 4th byte, or on s_last with fewer bytes (unfilled bytes = 0), -> WRITE.
//  - WRITE: s_ready=0. If words_loaded < 2**IW: wr_en=1 for exactly this cycle,
//    wr_addr=words_loaded, wr_data=pack reg; words_loaded++ on this edge.
//    Then -> DONE if last seen, else RECV (pack reg and byte index cleared).
//    If words_loaded == 2**IW (overflow): no write, err<=1, -> DRAIN (or DONE if last seen).
//  - DRAIN: s_ready=1, bytes discarded; on s_last transfer -> DONE.
//  - DONE: done=1 one cycle, busy still 1; -> IDLE.
//  - Timing: wr_en asserts the cycle after the 4th byte transfer; peak rate 4 bytes per
//    5 cycles. done asserts the cycle after the final write (or the s_last in DRAIN).
//  - Exactly 2**IW full words: no err; 2**IW-th write to address 2**IW-1, words_loaded=2**IW.
//  - reset_n mid-load: immediate abort; partial word discarded; words already written stay.
//  - s_valid low in RECV: wait indefinitely, no timeout.
// STRUCTURE
//  - Package definitions gains: typedef enum logic [2:0] {LD_IDLE, LD_RECV, LD_WRITE,
//    LD_DRAIN, LD_DONE} loader_state_t; localparam BYTES_PER_WORD = 4. Reuses existing
//    ProgramCounter and Instruction typedefs.
//  - Single module; byte packing is a small always_ff block, no sub-module.
// TESTING (IW=4, bench memory model + Instruction array scoreboard)
//  - Reset: hold reset_n=0 with random inputs -> all outputs 0, s_ready=0; release, idle stays quiet.
//  - Load 8 bytes 12 34 56 78 DE AD BE EF (last on EF) -> writes [0]=0x12345678,
//    [1]=0xDEADBEEF; words_loaded=2; done one pulse; err=0.
//  - Partial word: bytes AA BB CC with last on CC -> single write [0]=0xAABBCC00, done.
//  - Overflow: 17 words (68 bytes) -> 16 writes addr 0..15; 17th not written; err=1 and
//    stays 1 after done; next start clears err.
//  - Back-pressure/gaps: random s_valid gaps, start pulses while busy -> same data as
//    gap-free run, starts ignored, wr_en never asserted with s_ready=1.
//  - Reset mid-load: reset_n low after 6 bytes -> only [0] written, outputs 0; new load ok.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: PC/instruction words,
// loader FSM states and the stream packing ratio.
package imem_loader_pkg;

    typedef logic [31:0] ProgramCounter;
    typedef logic [31:0] Instruction;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_RECV,
        LD_WRITE,
        LD_DRAIN,
        LD_DONE
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader.sv
// Run-time instruction RAM loader: packs a big-endian byte stream into
// 32-bit words written from address 0, holding the CPU while busy.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int IW = 4
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic          wr_en,
    output ProgramCounter wr_addr,
    output Instruction    wr_data,
    output logic          busy,
    output logic          hold_cpu,
    output logic          done,
    output logic          err,
    output logic [IW:0]   words_loaded
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    loader_state_t    r_state;
    loader_state_t    w_next;
    Instruction       r_pack;
    logic [IDX_W-1:0] r_idx;
    logic             r_last;
    logic [IW:0]      r_words;
    logic             r_err;
    logic             w_xfer;
    logic             w_full;

    assign w_xfer = s_valid && s_ready;
    // Count never exceeds 2**IW, so the top bit alone marks a full memory
    assign w_full = r_words[IW];

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            LD_IDLE: begin
                if (start) w_next = LD_RECV;
            end
            LD_RECV: begin
                if (w_xfer && (s_last || r_idx == LAST_IDX)) begin
                    w_next = LD_WRITE;
                end
            end
            LD_WRITE: begin
                if (r_last) begin
                    w_next = LD_DONE;
                end else if (w_full) begin
                    w_next = LD_DRAIN;
                end else begin
                    w_next = LD_RECV;
                end
            end
            LD_DRAIN: begin
                if (w_xfer && s_last) w_next = LD_DONE;
            end
            LD_DONE: begin
                w_next = LD_IDLE;
            end
            default: begin
                w_next = LD_IDLE;
            end
        endcase
    end

    always_comb begin
        s_ready  = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        s_ready  = (r_state == LD_RECV) || (r_state == LD_DRAIN);
        wr_en    = (r_state == LD_WRITE) && !w_full;
        busy     = (r_state != LD_IDLE);
        done     = (r_state == LD_DONE);
        hold_cpu = busy;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_pack  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                LD_IDLE: begin
                    if (start) begin
                        r_pack  <= '0;
                        r_idx   <= '0;
                        r_last  <= 1'b0;
                        r_words <= '0;
                        r_err   <= 1'b0;
                    end
                end
                LD_RECV: begin
                    if (w_xfer) begin
                        unique case (r_idx)
                            2'd0:    r_pack[31:24] <= s_data;
                            2'd1:    r_pack[23:16] <= s_data;
                            2'd2:    r_pack[15:8]  <= s_data;
                            default: r_pack[7:0]   <= s_data;
                        endcase
                        r_idx  <= r_idx + IDX_W'(1);
                        r_last <= s_last;
                    end
                end
                LD_WRITE: begin
                    if (w_full) begin
                        r_err <= 1'b1;
                    end else begin
                        r_words <= r_words + (IW+1)'(1);
                    end
                    r_pack <= '0;
                    r_idx  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign wr_addr      = {{(32-IW){1'b0}}, r_words[IW-1:0]};
    assign wr_data      = r_pack;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed byte streams, a word-level
// model of the expected writes and a per-cycle compare process.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int IW    = 4;
    localparam int DEPTH = 16;

    logic          CLK = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          wr_en;
    ProgramCounter wr_addr;
    Instruction    wr_data;
    logic          busy;
    logic          hold_cpu;
    logic          done;
    logic          err;
    logic [IW:0]   words_loaded;

    imem_loader #(.IW(IW)) dut (
        .CLK(CLK), .reset_n(reset_n), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .hold_cpu(hold_cpu),
        .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected writes of the current load, derived from the byte list
    logic [7:0] tx[$];
    Instruction exp_w[DEPTH];
    int         exp_cnt = 0;
    bit         exp_err = 0;
    int         wr_base = 0;

    // Memory model and event counters, owned by the compare process
    Instruction mem_m[DEPTH];
    int         n_wr = 0;
    int         done_cnt = 0;
    bit         prev_xfer = 0;

    function automatic void build_model();
        int n  = tx.size();
        int nw = (n + 3) / 4;
        for (int w = 0; w < DEPTH; w++) begin
            Instruction v = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < n) v[31 - 8 * k -: 8] = tx[4 * w + k];
            end
            exp_w[w] = v;
        end
        exp_cnt = (nw < DEPTH) ? nw : DEPTH;
        exp_err = (nw > DEPTH);
    endfunction

    always @(negedge CLK) begin
        if (!reset_n) begin
            prev_xfer = 0;
        end else begin
            int idx;
            chk("no_wr_while_ready", wr_en && s_ready, 0);
            chk("hold_eq_busy", hold_cpu, busy);
            if (wr_en) begin
                idx = n_wr - wr_base;
                chk("wr_after_xfer", prev_xfer, 1);
                chk("wr_addr", wr_addr, idx);
                if (idx >= exp_cnt) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wr: got write %0d expected %0d writes", idx, exp_cnt);
                end else begin
                    chk("wr_data", wr_data, exp_w[idx]);
                end
                mem_m[wr_addr[IW-1:0]] = wr_data;
                n_wr++;
            end
            if (done) begin
                done_cnt++;
                chk("done_while_busy", busy, 1);
            end
            prev_xfer = s_valid && s_ready;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input bit gaps, input bit use_last);
        int i = 0;
        int guard = 0;
        while (i < tx.size() && guard < 2000) begin
            bit x;
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = tx[i];
                s_last  = use_last && (i == tx.size() - 1);
            end
            start = gaps && ($urandom_range(0, 4) == 0);
            x = s_valid && s_ready;
            tick();
            if (x) i++;
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        if (i < tx.size()) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got %0d bytes expected %0d", i, tx.size());
        end
    endtask

    task automatic run_load(input string tag, input bit gaps);
        int d0;
        int g = 0;
        build_model();
        wr_base = n_wr;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send(gaps, 1'b1);
        while (busy && g < 200) begin
            tick();
            g++;
        end
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_words_loaded"}, words_loaded, exp_cnt);
        chk({tag, "_writes"}, n_wr - wr_base, exp_cnt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {s_ready, wr_en, busy, hold_cpu, done, err}, 0);
        chk({tag, "_addr"}, wr_addr, 0);
        chk({tag, "_data"}, wr_data, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs: everything quiet
        reset_n = 1'b0;
        repeat (5) begin
            tick();
            s_valid = 1'($urandom);
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
            start   = 1'($urandom);
            @(negedge CLK);
            chk_all_zero("reset");
        end
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b0;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("idle_quiet", {s_ready, wr_en, busy, done, err}, 0);
        end
        tick();
        s_valid = 1'b0;

        tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load("load8", 1'b0);
        chk("load8_mem0", mem_m[0], 32'h12345678);
        chk("load8_mem1", mem_m[1], 32'hDEADBEEF);

        tx = '{8'hAA, 8'hBB, 8'hCC};
        run_load("partial", 1'b0);
        chk("partial_mem0", mem_m[0], 32'hAABBCC00);

        tx.delete();
        for (int i = 0; i < 64; i++) tx.push_back(8'(i));
        run_load("exact16", 1'b0);
        chk("exact16_mem0", mem_m[0], 32'h00010203);
        chk("exact16_mem15", mem_m[15], 32'h3C3D3E3F);

        tx.delete();
        for (int i = 0; i < 68; i++) tx.push_back(8'(i + 1));
        run_load("ovf68", 1'b0);
        chk("ovf68_mem15", mem_m[15], 32'h3D3E3F40);
        repeat (3) begin
            @(negedge CLK);
            chk("ovf68_err_sticky", err, 1);
        end
        tick();

        tx.delete();
        for (int i = 0; i < 71; i++) tx.push_back(8'(i) ^ 8'hFF);
        run_load("ovf71_drain", 1'b1);
        chk("ovf71_mem15", mem_m[15], 32'hC3C2C1C0);

        tx = '{8'hAA, 8'hBB, 8'hCC};
        run_load("err_clear", 1'b0);
        chk("err_clear_mem0", mem_m[0], 32'hAABBCC00);

        tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load("gaps", 1'b1);
        chk("gaps_mem0", mem_m[0], 32'h12345678);
        chk("gaps_mem1", mem_m[1], 32'hDEADBEEF);

        // Abort after six bytes: only the first word reaches memory
        tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        build_model();
        wr_base = n_wr;
        start = 1'b1;
        tick();
        start = 1'b0;
        send(1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        chk("midrst_writes", n_wr - wr_base, 1);
        chk("midrst_mem0", mem_m[0], 32'h11223344);
        chk("midrst_mem1_kept", mem_m[1], 32'hDEADBEEF);
        tick();
        reset_n = 1'b1;
        tick();

        tx = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("after_rst", 1'b0);
        chk("after_rst_mem0", mem_m[0], 32'h01020304);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
